// File: rtl/riscv_test_monitor.sv
// Test-completion monitor: snoops register-file writes to a done/result register pair
// and reports a registered pass/fail/timeout verdict plus the elapsed RUN cycle count.
module riscv_test_monitor #(
  parameter int DATA_W        = 32,
  parameter int ADDR_W        = 5,
  parameter int DONE_REG      = 26,
  parameter int PASS_REG      = 27,
  parameter int CNT_W         = 32,
  parameter int TIMEOUT       = 0,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              clear_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic              fail_o,
  output logic              timeout_o,
  output logic [CNT_W-1:0]  elapsed_o
);

  localparam int SW = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [SW-1:0]     SETTLE_LD = SW'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] DONE_IDX  = ADDR_W'(DONE_REG);
  localparam logic [ADDR_W-1:0] PASS_IDX  = ADDR_W'(PASS_REG);

  typedef enum logic [2:0] {S_RUN, S_SETTLE, S_PASS, S_FAIL, S_TMO} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SW-1:0]     settle_q, settle_d;
  logic [DATA_W-1:0] done_q, done_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              done_any, done_hit, pass_wr;

  // Index 0 is hard-wired zero in the register file, so it can never act as a monitor register.
  assign done_any = we_i && (waddr_i == DONE_IDX) && (DONE_IDX != '0);
  assign done_hit = done_any && (wdata_i == DATA_W'(1));
  assign pass_wr  = we_i && (waddr_i == PASS_IDX) && (PASS_IDX != '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    settle_d = settle_q;
    done_d   = done_q;
    result_d = result_q;
    if (clear_i) begin
      state_d  = S_RUN;
      cnt_d    = '0;
      settle_d = '0;
      done_d   = '0;
      result_d = '0;
    end else if (state_q == S_RUN || state_q == S_SETTLE) begin
      if (pass_wr)  result_d = wdata_i;
      if (done_any) done_d   = wdata_i;
      if (state_q == S_RUN) begin
        if (done_hit) begin
          state_d  = S_SETTLE;
          settle_d = SETTLE_LD;
        end else begin
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          if (TIMEOUT != 0 && cnt_q == TO_LAST) state_d = S_TMO;
        end
      end else begin
        // result_d already holds a same-edge PASS_REG write, so a late result still counts.
        if (settle_q == '0) state_d = (result_d == DATA_W'(1)) ? S_PASS : S_FAIL;
        else                settle_d = settle_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_RUN;
      cnt_q    <= '0;
      settle_q <= '0;
      done_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  // done_q is a debug shadow of the done register; nothing inside the monitor consumes it.
  logic unused_done_shadow;
  assign unused_done_shadow = ^done_q;

  assign busy_o    = (state_q == S_RUN) || (state_q == S_SETTLE);
  assign pass_o    = (state_q == S_PASS);
  assign fail_o    = (state_q == S_FAIL);
  assign timeout_o = (state_q == S_TMO);
  assign done_o    = pass_o || fail_o || timeout_o;
  assign elapsed_o = cnt_q;

endmodule
